// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port front end for a shared combinational ALU.
// Each operation takes three cycles: accept in IDLE, drive the ALU in EXEC, hold the tagged result in RESP.
module alu_arbiter #(
   parameter int WIDTH = 64,
   parameter int CTRLW = 4
) (
   input  logic             CLK,
   input  logic             resetl,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [CTRLW-1:0] req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [CTRLW-1:0] req1_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [CTRLW-1:0] alu_ctrl,
   input  logic [WIDTH-1:0] alu_w,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_err
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;
   stateT state, nextState;
   logic rrPtr, opId, grant1, accept, illegal;
   assign grant1 = req1_valid & (~req0_valid | rrPtr);
   assign accept = req0_ready | req1_ready;
   assign illegal = !(alu_ctrl inside {CTRLW'(0), CTRLW'(1), CTRLW'(2), CTRLW'(6), CTRLW'(7)});
   always_ff @(posedge CLK or negedge resetl)
      if (!resetl) state <= IDLE;
      else state <= nextState;
   // ready is gated by resetl so that nothing looks accepted while reset is held
   always_comb begin
      nextState = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid = state == RESP;
      req0_ready = resetl && state == IDLE && req0_valid && !grant1;
      req1_ready = resetl && state == IDLE && grant1;
      nextState = state == IDLE ? ((req0_valid | req1_valid) ? EXEC : IDLE) :
                  state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
   end
   always_ff @(posedge CLK or negedge resetl)
      if (!resetl) begin
         rrPtr <= 1'b0;
         opId <= 1'b0;
         alu_a <= '0;
         alu_b <= '0;
         alu_ctrl <= '0;
         rsp_id <= 1'b0;
         rsp_data <= '0;
         rsp_zero <= 1'b0;
         rsp_err <= 1'b0;
      end else begin
         if (accept) begin
            alu_a <= grant1 ? req1_a : req0_a;
            alu_b <= grant1 ? req1_b : req0_b;
            alu_ctrl <= grant1 ? req1_ctrl : req0_ctrl;
            opId <= grant1;
            rrPtr <= ~grant1;
         end
         if (state == EXEC) begin
            rsp_data <= alu_w;
            rsp_zero <= alu_zero;
            rsp_err <= illegal;
            rsp_id <= opId;
         end
      end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against a behavioural ALU and hand-computed results.
module tb_alu_arbiter;
   logic        CLK = 1'b0;
   logic        resetl;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [63:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_ctrl, req1_ctrl;
   logic [63:0] alu_a, alu_b, alu_w;
   logic [3:0]  alu_ctrl;
   logic        alu_zero;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [63:0] rsp_data;
   int tests = 0;
   int fails = 0;

   alu_arbiter #(.WIDTH(64), .CTRLW(4)) dut (
      .CLK(CLK), .resetl(resetl),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_w(alu_w), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   always #5 CLK = ~CLK;

   // external ALU stand-in: AND, OR, ADD, SUB, PassB, everything else yields 0
   assign alu_w = alu_ctrl == 4'b0000 ? (alu_a & alu_b) :
                  alu_ctrl == 4'b0001 ? (alu_a | alu_b) :
                  alu_ctrl == 4'b0010 ? (alu_a + alu_b) :
                  alu_ctrl == 4'b0110 ? (alu_a - alu_b) :
                  alu_ctrl == 4'b0111 ? alu_b : 64'd0;
   assign alu_zero = alu_w == 64'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chkRsp(input string tag, input logic id, input logic [63:0] data, input logic zero, input logic err);
      chk({tag, ".valid"}, rsp_valid, 1);
      chk({tag, ".id"}, rsp_id, id);
      chk({tag, ".data"}, rsp_data, data);
      chk({tag, ".zero"}, rsp_zero, zero);
      chk({tag, ".err"}, rsp_err, err);
   endtask

   task automatic chkQuiet(input string tag);
      chk({tag, ".req0_ready"}, req0_ready, 0);
      chk({tag, ".req1_ready"}, req1_ready, 0);
      chk({tag, ".rsp_valid"}, rsp_valid, 0);
      chk({tag, ".rsp_id"}, rsp_id, 0);
      chk({tag, ".rsp_data"}, rsp_data, 0);
      chk({tag, ".rsp_zero"}, rsp_zero, 0);
      chk({tag, ".rsp_err"}, rsp_err, 0);
      chk({tag, ".alu_a"}, alu_a, 0);
      chk({tag, ".alu_b"}, alu_b, 0);
      chk({tag, ".alu_ctrl"}, alu_ctrl, 0);
   endtask

   initial begin
      resetl = 1'b0;
      rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
      tick();
      tick();
      chkQuiet("reset");
      resetl = 1'b1;
      tick();
      chk("idle.rsp_valid", rsp_valid, 0);

      // contention: req0 SUB 9-9, req1 OR F0|0F, both held valid
      req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd9; req0_ctrl = 4'b0110;
      req1_valid = 1'b1; req1_a = 64'hF0; req1_b = 64'h0F; req1_ctrl = 4'b0001;
      #1;
      chk("cont.g0.req0_ready", req0_ready, 1);
      chk("cont.g0.req1_ready", req1_ready, 0);
      tick();
      chk("cont.exec.rsp_valid", rsp_valid, 0);
      chk("cont.exec.alu_ctrl", alu_ctrl, 4'b0110);
      chk("cont.exec.req0_ready", req0_ready, 0);
      tick();
      chkRsp("cont.r0", 0, 64'd0, 1, 0);
      chk("cont.r0.req1_ready", req1_ready, 0);
      tick();
      chk("cont.g1.req0_ready", req0_ready, 0);
      chk("cont.g1.req1_ready", req1_ready, 1);
      chk("cont.g1.rsp_valid", rsp_valid, 0);
      tick();
      tick();
      chkRsp("cont.r1", 1, 64'hFF, 0, 0);
      tick();
      chk("cont.g2.req0_ready", req0_ready, 1);
      chk("cont.g2.req1_ready", req1_ready, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk("cont.drop.req0_ready", req0_ready, 0);
      tick();
      chk("cont.drop.rsp_valid", rsp_valid, 0);

      // single request: ADD 5+7
      req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd7; req0_ctrl = 4'b0010;
      #1;
      chk("single.req0_ready", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      chk("single.exec.rsp_valid", rsp_valid, 0);
      chk("single.alu_a", alu_a, 64'd5);
      chk("single.alu_b", alu_b, 64'd7);
      tick();
      chkRsp("single", 0, 64'd12, 0, 0);
      tick();
      chk("single.done.rsp_valid", rsp_valid, 0);

      // backpressure: req1 PassB 0xDEAD held for 5 cycles while both requesters wait
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 64'd0; req1_b = 64'hDEAD; req1_ctrl = 4'b0111;
      #1;
      chk("bp.req1_ready", req1_ready, 1);
      tick();
      req1_b = 64'h1234;
      req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd1; req0_ctrl = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         tick();
         chkRsp($sformatf("bp.hold%0d", i), 1, 64'hDEAD, 0, 0);
         chk($sformatf("bp.hold%0d.req0_ready", i), req0_ready, 0);
         chk($sformatf("bp.hold%0d.req1_ready", i), req1_ready, 0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp.release.req0_ready", req0_ready, 0);
      chk("bp.release.req1_ready", req1_ready, 0);
      tick();
      chk("bp.idle.rsp_valid", rsp_valid, 0);
      chk("bp.idle.req0_ready", req0_ready, 1);
      chk("bp.idle.req1_ready", req1_ready, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      // wrap-around ADD and illegal ctrl
      req0_valid = 1'b1; req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'd1; req0_ctrl = 4'b0010;
      tick();
      req0_valid = 1'b0;
      tick();
      chkRsp("wrap", 0, 64'd0, 1, 0);
      tick();
      req1_valid = 1'b1; req1_a = 64'd3; req1_b = 64'd4; req1_ctrl = 4'b1111;
      #1;
      chk("illegal.req1_ready", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      tick();
      chkRsp("illegal", 1, 64'd0, 1, 1);
      tick();

      // pointer: req0 alone, req1 alone, then both -> req0 wins first
      req0_valid = 1'b1; req0_a = 64'hC; req0_b = 64'hA; req0_ctrl = 4'b0000;
      tick();
      req0_valid = 1'b0;
      tick();
      chkRsp("rr.and", 0, 64'h8, 0, 0);
      tick();
      req1_valid = 1'b1; req1_a = 64'd2; req1_b = 64'd3; req1_ctrl = 4'b0010;
      tick();
      req1_valid = 1'b0;
      tick();
      chkRsp("rr.solo1", 1, 64'd5, 0, 0);
      tick();
      req0_valid = 1'b1; req0_a = 64'd10; req0_b = 64'd4; req0_ctrl = 4'b0110;
      req1_valid = 1'b1;
      #1;
      chk("rr.both.req0_ready", req0_ready, 1);
      chk("rr.both.req1_ready", req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      tick();
      chkRsp("rr.first", 0, 64'd6, 0, 0);
      tick();
      chk("rr.second.req1_ready", req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      tick();
      chkRsp("rr.second", 1, 64'd5, 0, 0);
      tick();

      // asynchronous reset in the middle of EXEC with req0 still pending
      req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2; req0_ctrl = 4'b0010;
      tick();
      chk("rst.exec.alu_a", alu_a, 64'd1);
      #2;
      resetl = 1'b0;
      #1;
      chkQuiet("rst.mid");
      req0_valid = 1'b0;
      tick();
      resetl = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rst.after%0d.rsp_valid", i), rsp_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
